universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised successor to the 4-bit serial-in shift register. Adds
//  parameterised width, selectable shift direction, parallel load,
//  rotate mode, an enable and a word-boundary counter.
//  Serves as the serialiser/deserialiser primitive for later lab datapaths,
//  e.g. UART-style bit streams and LFSR seeding.
// PARAMETERS
//  WIDTH        4      register width in bits; legal range >= 2
//  RESET_VALUE  0      value loaded into out on rst (WIDTH bits)
// PORTS
//  clk          input   1            rising-edge clock
//  rst          input   1            asynchronous, active-high reset
//  en           input   1            1 = mode takes effect this edge; 0 = hold everything
//  mode         input   2            00 hold, 01 shift left, 10 shift right, 11 parallel load
//  rotate       input   1            1 = circular shift; serial input ignored
//  sin          input   1            serial data in
//  pin          input   WIDTH        parallel load data
//  out          output  WIDTH        register contents
//  sout_msb     output  1            equals out[WIDTH-1] (combinational)
//  sout_lsb     output  1            equals out[0] (combinational)
//  shift_count  output  $clog2(WIDTH+1)  shifts since last load/reset/wrap
//  word_done    output  1            one-cycle pulse: WIDTH shifts completed
// BEHAVIOUR
//  - rst high, at any time, async: out=RESET_VALUE, shift_count=0, word_done=0.
//    Held while rst is high; the first edge after deassert acts on inputs.
//  - All updates are on posedge clk. Outputs are registered except sout_*.
//  - en=0: out and shift_count hold, word_done<=0.
//  - en=1, mode 00: same as en=0.
//  - en=1, mode 01: out <= {out[WIDTH-2:0], rotate ? out[WIDTH-1] : sin}.
//  - en=1, mode 10: out <= {rotate ? out[0] : sin, out[WIDTH-1:1]}.
//  - en=1, mode 11: out <= pin, shift_count<=0, word_done<=0.
//    rotate and sin are ignored in this mode.
//  - Counter: each shift (mode 01/10 with en=1) increments shift_count.
//    If shift_count == WIDTH-1 on a shift edge:
//    shift_count<=0 (wrap) and word_done<=1 for exactly the next cycle.
//    Otherwise word_done<=0.
//  - Back-to-back words: after a wrap, counting restarts immediately.
//    word_done pulses every WIDTH shifts with no dead cycle.
//  - Direction change mid-word does not reset shift_count.
//    Left and right shifts both count.
//  - Load on the edge that would have wrapped: the load wins.
//    shift_count=0, word_done=0, no pulse.
//  - Latency: out reflects a shift/load 1 cycle after the sampling edge.
//    sout_* follow out with zero additional latency.
//  - No X propagation from sin when rotate=1 or mode is 00/11.
// TESTING (WIDTH=4, RESET_VALUE=0 unless stated)
//  1 Reset: rst=1 mid-stream with out=1011 -> out=0000 and shift_count=0
//    immediately, before the next clk; word_done=0.
//  2 Shift left, sin=1,0,1,1 on 4 en edges -> out=0001,0010,0101,1011.
//    word_done=1 only in the cycle after the 4th edge; shift_count=0 then.
//    Check each step against {prev_out[2:0],sin}.
//  3 Load pin=1000, then rotate=1 shift right x4 -> out=0100,0010,0001,1000.
//    word_done pulses after the 4th shift.
//  4 en=0 with mode=01 for 3 cycles -> out and shift_count unchanged.
//    word_done stays 0.
//  5 3 shifts then load pin=0110 -> out=0110, shift_count=0.
//    The 4th subsequent shift yields the first word_done pulse.
//  6 Random: 200 cycles of random en/mode/rotate/sin/pin.
//    Compare out/shift_count/word_done to a behavioural model each cycle.
//    Repeat with WIDTH=8, RESET_VALUE=8'hA5.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift left, shift right (serial fill or
// rotate) and parallel load, gated by en. A word-boundary counter tracks
// shifts since the last load/reset/wrap and pulses word_done after every
// WIDTH shifts, so the block can frame serial streams directly.
module universal_shift_register #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_count,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic             do_shift;
  logic             do_load;
  logic             wrap;
  logic             fill_bit;
  logic [WIDTH-1:0] out_nxt;

  // Decode the operation for this edge and form the next register value.
  // The fill bit is a mux rather than a gate so sin cannot leak into out
  // when rotating or when the mode ignores it.
  always_comb begin
    do_shift = en && ((mode == MODE_LEFT) || (mode == MODE_RIGHT));
    do_load  = en && (mode == MODE_LOAD);
    wrap     = do_shift && (shift_count == CW'(WIDTH - 1));
    fill_bit = sin;
    out_nxt  = out;
    if (mode == MODE_LEFT) begin
      fill_bit = rotate ? out[WIDTH-1] : sin;
      out_nxt  = {out[WIDTH-2:0], fill_bit};
    end else if (mode == MODE_RIGHT) begin
      fill_bit = rotate ? out[0] : sin;
      out_nxt  = {fill_bit, out[WIDTH-1:1]};
    end else if (mode == MODE_LOAD) begin
      out_nxt  = pin;
    end else if (mode == MODE_HOLD) begin
      out_nxt  = out;
    end
  end

  // Register contents, word counter and the one-cycle word_done pulse.
  // A load on what would have been the wrap edge clears the count and
  // suppresses the pulse because wrap is only true for shift edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out         <= RESET_VALUE;
      shift_count <= '0;
      word_done   <= 1'b0;
    end else begin
      word_done <= wrap;
      if (do_load) begin
        out         <= out_nxt;
        shift_count <= '0;
      end else if (do_shift) begin
        out         <= out_nxt;
        shift_count <= wrap ? '0 : shift_count + 1'b1;
      end
    end
  end

  // Serial taps are straight wires off the register.
  always_comb begin
    sout_msb = out[WIDTH-1];
    sout_lsb = out[0];
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: a directed vector table for the
// WIDTH=4 corner cases, a hand-written async reset sequence, then random
// stimulus against an arithmetic reference model for WIDTH=4 and
// WIDTH=8/RESET_VALUE=8'hA5 instances driven side by side.
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       rotate;
  logic       sin;
  logic [3:0] pin4;
  logic [7:0] pin8;

  logic [3:0] out4;
  logic       msb4, lsb4, done4;
  logic [2:0] cnt4;
  logic [7:0] out8;
  logic       msb8, lsb8, done8;
  logic [3:0] cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  longint m4_val, m8_val;
  int     m4_cnt, m8_cnt;
  bit     m4_done, m8_done;

  universal_shift_register #(.WIDTH(4), .RESET_VALUE(4'h0)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate), .sin(sin),
    .pin(pin4), .out(out4), .sout_msb(msb4), .sout_lsb(lsb4),
    .shift_count(cnt4), .word_done(done4)
  );

  universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate), .sin(sin),
    .pin(pin8), .out(out8), .sout_msb(msb8), .sout_lsb(lsb8),
    .shift_count(cnt8), .word_done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       rotate;
    logic       sin;
    logic [3:0] pin;
    logic [3:0] exp_out;
    int         exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural next state from plain arithmetic on the word value.
  task automatic model_next(input int w, input logic e, input logic [1:0] m,
                            input logic r, input logic s, input longint p,
                            input longint v_in, input int c_in,
                            output longint v_out, output int c_out, output bit d_out);
    longint span;
    longint b;
    span  = longint'(1) << w;
    v_out = v_in;
    c_out = c_in;
    d_out = 1'b0;
    if (e && m == 2'd3) begin
      v_out = p;
      c_out = 0;
    end else if (e && (m == 2'd1 || m == 2'd2)) begin
      if (m == 2'd1) begin
        b     = r ? (v_in / (span / 2)) : longint'(s);
        v_out = (v_in * 2 + b) % span;
      end else begin
        b     = r ? (v_in % 2) : longint'(s);
        v_out = v_in / 2 + b * (span / 2);
      end
      c_out = c_in + 1;
      if (c_out == w) begin
        c_out = 0;
        d_out = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m4_val = 0;    m4_cnt = 0; m4_done = 0;
    m8_val = 'hA5; m8_cnt = 0; m8_done = 0;
  endtask

  task automatic check8();
    check("out8", out8, m8_val);
    check("cnt8", cnt8, m8_cnt);
    check("done8", done8, m8_done);
    check("msb8", msb8, m8_val / 128);
    check("lsb8", lsb8, m8_val % 2);
  endtask

  task automatic check4_model();
    check("out4", out4, m4_val);
    check("cnt4", cnt4, m4_cnt);
    check("done4", done4, m4_done);
    check("msb4", msb4, m4_val / 8);
    check("lsb4", lsb4, m4_val % 2);
  endtask

  // Apply one cycle of stimulus, advance both models, check the 8-bit DUT.
  task automatic drive(input logic e, input logic [1:0] m, input logic r,
                       input logic s, input logic [3:0] p4, input logic [7:0] p8);
    longint v;
    int     c;
    bit     d;
    @(negedge clk);
    en = e; mode = m; rotate = r; sin = s; pin4 = p4; pin8 = p8;
    @(posedge clk);
    model_next(4, e, m, r, s, longint'(p4), m4_val, m4_cnt, v, c, d);
    m4_val = v; m4_cnt = c; m4_done = d;
    model_next(8, e, m, r, s, longint'(p8), m8_val, m8_cnt, v, c, d);
    m8_val = v; m8_cnt = c; m8_done = d;
    #1;
    check8();
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic r,
                              input logic s, input logic [3:0] p,
                              input logic [3:0] o, input int c, input logic d);
    vec_t t;
    t.en = e; t.mode = m; t.rotate = r; t.sin = s; t.pin = p;
    t.exp_out = o; t.exp_cnt = c; t.exp_done = d;
    return t;
  endfunction

  initial begin
    // shift left with serial data 1,0,1,1
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 4'h0, 4'b0010, 2, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b0101, 3, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b1011, 0, 1));
    // en=0 holds everything, mode 00 holds too
    vecs.push_back(mk(0, 2'b01, 0, 1, 4'h0, 4'b1011, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 0, 4'h0, 4'b1011, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 1, 4'h0, 4'b1011, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 1, 4'hF, 4'b1011, 0, 0));
    // load then rotate right x4 (sin ignored while rotating)
    vecs.push_back(mk(1, 2'b11, 1, 1, 4'b1000, 4'b1000, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 4'h0, 4'b0100, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 4'h0, 4'b0010, 2, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 4'h0, 4'b0001, 3, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 4'h0, 4'b1000, 0, 1));
    // three shifts, then a load on the would-be wrap edge
    vecs.push_back(mk(1, 2'b01, 0, 0, 4'h0, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 4'h0, 4'b0000, 2, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 4'h0, 4'b0000, 3, 0));
    vecs.push_back(mk(1, 2'b11, 0, 1, 4'b0110, 4'b0110, 0, 0));
    // four shifts with a direction change mid-word, then back-to-back word
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b1101, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 4'h0, 4'b0110, 2, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b1101, 3, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 4'h0, 4'b1011, 0, 1));
    vecs.push_back(mk(1, 2'b01, 0, 0, 4'h0, 4'b0110, 1, 0));

    rst = 1'b1; en = 1'b0; mode = 2'b00; rotate = 1'b0; sin = 1'b0;
    pin4 = '0; pin8 = '0;
    model_reset();
    #1;
    check("rst_out4", out4, 0);
    check("rst_cnt4", cnt4, 0);
    check("rst_done4", done4, 0);
    check8();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].rotate, vecs[i].sin, vecs[i].pin,
            8'($urandom));
      check($sformatf("vec%0d_out", i), out4, vecs[i].exp_out);
      check($sformatf("vec%0d_cnt", i), cnt4, vecs[i].exp_cnt);
      check($sformatf("vec%0d_done", i), done4, vecs[i].exp_done);
      check($sformatf("vec%0d_msb", i), msb4, vecs[i].exp_out[3]);
      check($sformatf("vec%0d_lsb", i), lsb4, vecs[i].exp_out[0]);
    end

    // async reset mid-stream while word_done is high and out=1011
    drive(1, 2'b11, 0, 0, 4'h0, 8'h00);
    drive(1, 2'b01, 0, 1, 4'h0, 8'h00);
    drive(1, 2'b01, 0, 0, 4'h0, 8'h00);
    drive(1, 2'b01, 0, 1, 4'h0, 8'h00);
    drive(1, 2'b01, 0, 1, 4'h0, 8'h00);
    check("pre_rst_out4", out4, 4'b1011);
    check("pre_rst_done4", done4, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_out4", out4, 0);
    check("async_rst_cnt4", cnt4, 0);
    check("async_rst_done4", done4, 0);
    check8();
    en = 1'b1; mode = 2'b01; sin = 1'b1;
    @(posedge clk);
    #1;
    check("held_rst_out4", out4, 0);
    check("held_rst_cnt4", cnt4, 0);
    check8();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;

    // random stimulus against the models
    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom), 8'($urandom));
      check4_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
